// File: rtl/run_detector_pkg.sv
// Shared constants and state encoding for the multi-lane run-length detector.
package run_detector_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HIT  = 2'd2
    } run_state_t;

endpackage

// File: rtl/run_detector_lane.sv
// One detector lane: run-length FSM, run counter and saturating hit counter.
module run_detector_lane
    import run_detector_pkg::*;
#(
    parameter int   RUN_LEN = 2,
    parameter logic TARGET  = 1'b0,
    parameter int   CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic             seq_bit,
    input  logic             overlap,
    input  logic             clear,
    output logic             hit,
    output logic             result,
    output logic [ST_W-1:0]  state,
    output logic [CNT_W-1:0] hit_cnt
);

    localparam int RC_W = $clog2(RUN_LEN + 1);
    localparam logic [RC_W-1:0]  RC_LAST = RC_W'(RUN_LEN - 1);
    localparam logic [RC_W-1:0]  RC_FULL = RC_W'(RUN_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    run_state_t       state_reg;
    logic [RC_W-1:0]  rc_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             result_reg;

    logic [RC_W-1:0]  base_rc;
    logic [RC_W-1:0]  n_rc;
    logic             legal;

    // The HIT state re-reads i_overlap so a mode change only bends the beat after a hit.
    always_comb begin
        base_rc = '0;
        legal   = 1'b1;
        case (state_reg)
            ST_IDLE: base_rc = '0;
            ST_RUN:  base_rc = rc_reg;
            ST_HIT:  base_rc = overlap ? RC_LAST : '0;
            default: legal = 1'b0;
        endcase
        n_rc = base_rc + 1'b1;
        hit  = valid && legal && (seq_bit == TARGET) && (n_rc == RC_FULL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            rc_reg     <= '0;
            cnt_reg    <= '0;
            result_reg <= 1'b0;
        end else begin
            result_reg <= hit;

            if (clear)
                cnt_reg <= '0;
            else if (hit && cnt_reg != CNT_MAX)
                cnt_reg <= cnt_reg + 1'b1;

            if (!legal) begin
                state_reg <= ST_IDLE;
                rc_reg    <= '0;
            end else if (valid) begin
                if (seq_bit == TARGET) begin
                    if (n_rc == RC_FULL) begin
                        state_reg <= ST_HIT;
                        rc_reg    <= overlap ? RC_LAST : '0;
                    end else begin
                        state_reg <= ST_RUN;
                        rc_reg    <= n_rc;
                    end
                end else begin
                    state_reg <= ST_IDLE;
                    rc_reg    <= '0;
                end
            end
        end
    end

    assign result  = result_reg;
    assign state   = state_reg;
    assign hit_cnt = cnt_reg;

endmodule

// File: rtl/run_detector.sv
// CH independent run-length detector lanes with a combined hit flag and packed debug outputs.
module run_detector
    import run_detector_pkg::*;
#(
    parameter int   CH      = 4,
    parameter int   RUN_LEN = 2,
    parameter logic TARGET  = 1'b0,
    parameter int   CNT_W   = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_valid,
    input  logic [CH-1:0]       i_seq,
    input  logic                i_overlap,
    input  logic                i_clear,
    output logic [CH-1:0]       result,
    output logic                o_any,
    output logic [ST_W*CH-1:0]  state,
    output logic [CNT_W*CH-1:0] o_hit_cnt
);

    logic [CH-1:0] hit_vec;
    logic          o_any_reg;

    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_lane
            run_detector_lane #(
                .RUN_LEN (RUN_LEN),
                .TARGET  (TARGET),
                .CNT_W   (CNT_W)
            ) u_lane (
                .clk     (clk),
                .reset   (reset),
                .valid   (i_valid),
                .seq_bit (i_seq[gi]),
                .overlap (i_overlap),
                .clear   (i_clear),
                .hit     (hit_vec[gi]),
                .result  (result[gi]),
                .state   (state[gi*ST_W +: ST_W]),
                .hit_cnt (o_hit_cnt[gi*CNT_W +: CNT_W])
            );
        end
    endgenerate

    // Built from the lanes' next-cycle hits so it lines up with the registered result bits.
    always_ff @(posedge clk) begin
        if (reset)
            o_any_reg <= 1'b0;
        else
            o_any_reg <= |hit_vec;
    end

    assign o_any = o_any_reg;

endmodule

// File: doc/run_detector.md
# run_detector

Parametrised multi-channel run-length detector: each of CH independent lanes watches a serial bit stream and flags every run of RUN_LEN consecutive TARGET bits. Overlapping and non-overlapping counting is selected at run time, and each lane keeps a saturating hit counter. The block is the general successor of the two-zero sequence detector. It sits directly behind serial/sampled inputs in the q-series designs, and its per-lane state and counts are exposed for debug.

## Interface
- CH, 4: number of independent lanes (≥1)
- RUN_LEN, 2: consecutive TARGET bits required for a hit (≥1)
- TARGET, 1'b0: bit value being counted
- CNT_W, 8: width of each per-lane hit counter (≥1)

- clk  input  1  single clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high; clears all state on the next rising edge of clk
- i_valid  input  1  beat qualifier shared by all lanes; lanes sample i_seq only when high
- i_seq  input  CH  one serial bit per lane
- i_overlap  input  1  1 = overlapping runs, 0 = non-overlapping; sampled each valid beat
- i_clear  input  1  synchronous clear of all hit counters only
- result  output  CH  per-lane one-cycle hit pulse (registered)
- o_any  output  1  OR of result (registered, same cycle as result)
- state  output  2*CH  per-lane FSM state, lane k at [2k+1:2k]
- o_hit_cnt  output  CNT_W*CH  per-lane saturating hit count, lane k at [CNT_W*(k+1)-1:CNT_W*k]

## Operation
- Per-lane run counter rc, width $clog2(RUN_LEN+1), range 0..RUN_LEN-1.
- States:
  - IDLE (0): rc==0, last valid beat was not TARGET, or after reset.
  - RUN (1): 0<rc<RUN_LEN.
  - HIT (2): the last valid beat completed a run.
  - Code 3 is unused; an illegal code recovers to IDLE on the next edge.
- On a valid beat with bit==TARGET, let n = rc+1 (rc treated as 0 from IDLE or non-overlap HIT, RUN_LEN-1 from overlap HIT):
  - n==RUN_LEN: hit. Next state HIT, result=1.
  - Non-overlap: rc←0.
  - Overlap: rc←RUN_LEN-1, so every further TARGET beat hits again.
  - Otherwise: rc←n, next state RUN.
- Valid beat with bit!=TARGET: rc←0, state IDLE, no hit.
- i_valid low: rc and state hold; result=0 (a pulse never stretches across stalls).
- RUN_LEN==1: every valid TARGET beat is a hit; RUN is never entered.
- Hit counter: increments by 1 on each hit and saturates at 2^CNT_W-1. i_clear zeroes all counters; i_clear beats a simultaneous hit (count=0), but result still pulses. i_clear does not affect rc or state.
- Changing i_overlap mid-stream affects only the transition taken on the beat following a hit.

## Timing
- Reset: state=IDLE, rc=0, result=0, o_any=0, o_hit_cnt=0 for all lanes. reset overrides i_valid, i_clear and any in-flight run.
- Latency: result[k] rises in the cycle after the clk edge that sampled the RUN_LEN-th TARGET beat, and lasts exactly one cycle unless another hit beat follows.
- result, o_any, state and o_hit_cnt all update on the same edge. The count reflects the hit in the same cycle result is high.
- Back-to-back valid beats in overlap mode give a continuous result=1 train, one pulse per beat.
- Lanes are fully independent; simultaneous hits on several lanes are all reported.

## Structure
- Package run_detector_pkg:
  - state enum/localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_HIT=2'd2
  - state width constant ST_W=2
- Sub-module run_detector_lane:
  - one lane's FSM, rc and hit counter
  - parameters RUN_LEN, TARGET, CNT_W
- Top: generate loop over CH lanes, plus the o_any register and output packing.

## Test plan
- Config CH=2, RUN_LEN=3, TARGET=0, overlap=0. Lane0 valid beats 0,0,0,0,0,0 → result[0] pulses after beats 3 and 6; state 1,1,2,1,1,2; count=2.
- Same stream with overlap=1 → result[0] high after beats 3,4,5,6; count=4.
- Lane0 beats 0,0,1,0,0,0 → no hit at beat 3, state IDLE at beat 3, single hit after beat 6. Meanwhile lane1 all 1s → result[1]=0 throughout.
- Stalls: beats 0, stall×3, 0, stall, 0 → state holds during stalls, single one-cycle pulse after the 3rd valid beat.
- CNT_W=2, overlap=1, 6 consecutive hits → count 1,2,3,3,3,3. i_clear asserted on a hit cycle → count 0, result still 1.
- reset asserted mid-run (state RUN, rc=2) → next cycle state=IDLE, count=0, result=0. A fresh RUN_LEN beats are then required before the next hit.
